temporal_encoder: RTL and testbench

Converts per-lane binary values into race-logic spikes inside fixed-length gamma cycles; it is the spike source feeding `wta_1`. Each lane's value sets the gamma-cycle slot of its rising edge, so a smaller value means an earlier spike. A one-cycle `gamma_start` marks the reset slot that downstream WTA/column logic uses as `rst`. A one-deep staging buffer allows back-to-back gamma cycles with no idle slot.

---
 rtl/spike_pkg.sv | 19 +
 rtl/spike_pulse_gen.sv | 53 +++++
 rtl/temporal_encoder.sv | 128 ++++++++++++
 tb/tb_temporal_encoder.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_pkg.sv
// Shared types and helpers for the race-logic temporal encoder.
// Holds the FSM state enum plus the gamma-derived width and NO_SPIKE code.
package spike_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } enc_state_t;

  function automatic int val_w(input int gamma);
    return $clog2(gamma);
  endfunction

  // gamma is a power of two, so gamma-1 is the all-ones lane code
  function automatic logic [31:0] NO_SPIKE(input int gamma);
    return 32'(gamma) - 32'd1;
  endfunction

endpackage

// File: rtl/spike_pulse_gen.sv
// Per-lane spike generator: registers the spike bit for the upcoming slot
// from the next count and the lane value that will be active in that slot.
module spike_pulse_gen
  import spike_pkg::*;
#(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  localparam int VAL_W            = val_w(GAMMA_CYCLE_WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_next,
  input  logic [VAL_W-1:0] count_next,
  input  logic [VAL_W-1:0] value,
  output logic             spike
);

  localparam logic [VAL_W-1:0] NO_SPIKE_V = VAL_W'(NO_SPIKE(GAMMA_CYCLE_WIDTH));
  localparam logic [VAL_W:0]   ONE_W      = (VAL_W+1)'(1);
  localparam logic [VAL_W:0]   PULSE_W    = (VAL_W+1)'(PULSE_WIDTH);

  logic           spike_d;
  logic           spike_q;
  logic [VAL_W:0] cnt_ext_s;
  logic [VAL_W:0] first_s;
  logic [VAL_W:0] last_s;

  // One extra bit keeps value+PULSE_WIDTH from wrapping; count never exceeds G-1,
  // so the pulse truncates at gamma end on its own.
  always_comb begin
    cnt_ext_s = {1'b0, count_next};
    first_s   = {1'b0, value} + ONE_W;
    last_s    = {1'b0, value} + PULSE_W;
    spike_d   = 1'b0;
    if (run_next && (value != NO_SPIKE_V)) begin
      spike_d = (cnt_ext_s >= first_s) && (cnt_ext_s <= last_s);
    end else begin
      spike_d = 1'b0;
    end
  end

  // Spike register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_q <= 1'b0;
    end else begin
      spike_q <= spike_d;
    end
  end

  assign spike = spike_q;

endmodule

// File: rtl/temporal_encoder.sv
// Temporal (race-logic) encoder: turns per-lane values into spikes timed within
// fixed gamma cycles, with a one-deep staging buffer for seamless back-to-back cycles.
module temporal_encoder
  import spike_pkg::*;
#(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  parameter int NUM_INPUTS        = 16,
  localparam int VAL_W            = val_w(GAMMA_CYCLE_WIDTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_INPUTS*VAL_W-1:0] in_values,
  output logic [NUM_INPUTS-1:0]       output_spikes,
  output logic                        gamma_start,
  output logic [VAL_W-1:0]            gamma_count,
  output logic                        busy
);

  localparam logic [VAL_W-1:0] LAST_SLOT = VAL_W'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [VAL_W-1:0] ONE_V     = VAL_W'(1);

  enc_state_t                  state_d, state_q;
  logic [VAL_W-1:0]            count_d, count_q;
  logic [NUM_INPUTS*VAL_W-1:0] active_d, active_q;
  logic [NUM_INPUTS*VAL_W-1:0] stage_d, stage_q;
  logic                        stage_full_d, stage_full_q;
  logic                        gamma_start_d, gamma_start_q;
  logic                        busy_d, busy_q;
  logic                        accept_s;

  assign in_ready = !stage_full_q;
  assign accept_s = in_valid && !stage_full_q;

  // Next-state, counter, buffer and handshake logic
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    active_d      = active_q;
    stage_d       = stage_q;
    stage_full_d  = stage_full_q;
    gamma_start_d = 1'b0;
    case (state_q)
      IDLE: begin
        count_d = {VAL_W{1'b0}};
        if (accept_s) begin
          state_d       = RUN;
          active_d      = in_values;
          gamma_start_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (count_q == LAST_SLOT) begin
          count_d = {VAL_W{1'b0}};
          // A staged vector wins; otherwise a same-edge accept restarts seamlessly
          if (stage_full_q) begin
            active_d      = stage_q;
            stage_full_d  = 1'b0;
            gamma_start_d = 1'b1;
          end else if (accept_s) begin
            active_d      = in_values;
            gamma_start_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          count_d = count_q + ONE_V;
          if (accept_s) begin
            stage_d      = in_values;
            stage_full_d = 1'b1;
          end else begin
            stage_full_d = stage_full_q;
          end
        end
      end
      default: begin
        state_d      = IDLE;
        count_d      = {VAL_W{1'b0}};
        stage_full_d = 1'b0;
      end
    endcase
    busy_d = (state_d == RUN);
  end

  // Control and buffer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      count_q       <= {VAL_W{1'b0}};
      active_q      <= {(NUM_INPUTS*VAL_W){1'b0}};
      stage_q       <= {(NUM_INPUTS*VAL_W){1'b0}};
      stage_full_q  <= 1'b0;
      gamma_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      active_q      <= active_d;
      stage_q       <= stage_d;
      stage_full_q  <= stage_full_d;
      gamma_start_q <= gamma_start_d;
      busy_q        <= busy_d;
    end
  end

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
    spike_pulse_gen #(
      .GAMMA_CYCLE_WIDTH(GAMMA_CYCLE_WIDTH),
      .PULSE_WIDTH      (PULSE_WIDTH)
    ) u_pulse (
      .clk       (clk),
      .rst       (rst),
      .run_next  (state_d == RUN),
      .count_next(count_d),
      .value     (active_d[i*VAL_W +: VAL_W]),
      .spike     (output_spikes[i])
    );
  end

  assign gamma_start = gamma_start_q;
  assign gamma_count = count_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_temporal_encoder.sv
// Directed self-checking bench for temporal_encoder at G=16, P=8, N=16.
module tb_temporal_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_values = 64'h0;
  logic [15:0] output_spikes;
  logic        gamma_start;
  logic [3:0]  gamma_count;
  logic        busy;

  int tests = 0;
  int fails = 0;

  temporal_encoder #(
    .GAMMA_CYCLE_WIDTH(16),
    .PULSE_WIDTH      (8),
    .NUM_INPUTS       (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_values    (in_values),
    .output_spikes(output_spikes),
    .gamma_start  (gamma_start),
    .gamma_count  (gamma_count),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] fill(input logic [3:0] v);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[i*4 +: 4] = v;
    return r;
  endfunction

  // Expected spikes from the value/slot rule: high for v+1 <= c <= min(v+8,15), never for v=15
  function automatic logic [15:0] exp_spk(input logic [63:0] v, input int c);
    logic [15:0] r;
    int lv, hi;
    for (int i = 0; i < 16; i++) begin
      lv = int'(v[i*4 +: 4]);
      hi = (lv + 8 > 15) ? 15 : lv + 8;
      r[i] = (lv != 15) && (c >= lv + 1) && (c <= hi);
    end
    return r;
  endfunction

  task automatic test_reset();
    #12;
    tests++;
    if ({output_spikes, gamma_start, gamma_count, busy, in_ready} !== {16'h0, 1'b0, 4'h0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset_hold: got spk=%h gs=%b cnt=%0d busy=%b rdy=%b want 0000/0/0/0/1",
               output_spikes, gamma_start, gamma_count, busy, in_ready);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    tick();
    tests++;
    if ({output_spikes, gamma_start, gamma_count, busy, in_ready} !== {16'h0, 1'b0, 4'h0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset_release: got spk=%h gs=%b cnt=%0d busy=%b rdy=%b want 0000/0/0/0/1",
               output_spikes, gamma_start, gamma_count, busy, in_ready);
    end
  endtask

  task automatic test_single();
    logic [63:0] v;
    logic [3:0]  want4;
    v = fill(4'hF);
    v[3:0] = 4'd0; v[7:4] = 4'd5; v[11:8] = 4'd14; v[15:12] = 4'd15;
    in_values = v;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    in_values = 64'h0;
    tests++;
    if ({gamma_count, gamma_start, busy, output_spikes} !== {4'd0, 1'b1, 1'b1, 16'h0}) begin
      fails++;
      $display("FAIL single_slot0: got cnt=%0d gs=%b busy=%b spk=%h want 0/1/1/0000",
               gamma_count, gamma_start, busy, output_spikes);
    end
    for (int c = 1; c < 16; c++) begin
      tick();
      want4 = {1'b0, (c == 15), (c >= 6 && c <= 13), (c >= 1 && c <= 8)};
      tests++;
      if ({gamma_count, gamma_start, output_spikes} !== {4'(c), 1'b0, 12'h0, want4}) begin
        fails++;
        $display("FAIL single_c%0d: got cnt=%0d gs=%b spk=%h want cnt=%0d gs=0 spk=%h",
                 c, gamma_count, gamma_start, output_spikes, c, {12'h0, want4});
      end
    end
    tick();
    tests++;
    if ({busy, gamma_count, gamma_start, output_spikes} !== {1'b0, 4'd0, 1'b0, 16'h0}) begin
      fails++;
      $display("FAIL single_idle: got busy=%b cnt=%0d gs=%b spk=%h want 0/0/0/0000",
               busy, gamma_count, gamma_start, output_spikes);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a, b;
    a = fill(4'd2);
    b = fill(4'd9);
    in_values = a; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c < 16; c++) begin
      if (c == 4) begin in_values = b; in_valid = 1'b1; end
      tick();
      if (c == 4) begin in_valid = 1'b0; in_values = 64'h0; end
      tests++;
      if ({gamma_count, output_spikes} !== {4'(c), exp_spk(a, c)}) begin
        fails++;
        $display("FAIL b2b_a_c%0d: got cnt=%0d spk=%h want cnt=%0d spk=%h",
                 c, gamma_count, output_spikes, c, exp_spk(a, c));
      end
      if (c >= 4) begin
        tests++;
        if (in_ready !== 1'b0) begin
          fails++;
          $display("FAIL b2b_ready_c%0d: got %b want 0", c, in_ready);
        end
      end
    end
    tick();
    tests++;
    if ({gamma_count, gamma_start, busy, output_spikes, in_ready} !== {4'd0, 1'b1, 1'b1, 16'h0, 1'b1}) begin
      fails++;
      $display("FAIL b2b_wrap: got cnt=%0d gs=%b busy=%b spk=%h rdy=%b want 0/1/1/0000/1",
               gamma_count, gamma_start, busy, output_spikes, in_ready);
    end
    for (int c = 1; c < 16; c++) begin
      tick();
      tests++;
      if ({gamma_count, output_spikes} !== {4'(c), exp_spk(b, c)}) begin
        fails++;
        $display("FAIL b2b_b_c%0d: got cnt=%0d spk=%h want cnt=%0d spk=%h",
                 c, gamma_count, output_spikes, c, exp_spk(b, c));
      end
    end
    tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_boundary_accept();
    logic [63:0] a, b;
    a = fill(4'd4);
    b = fill(4'd1);
    in_values = a; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (15) tick();
    tests++;
    if ({gamma_count, busy, in_ready} !== {4'd15, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL bnd_pre: got cnt=%0d busy=%b rdy=%b want 15/1/1", gamma_count, busy, in_ready);
    end
    in_values = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_values = 64'h0;
    tests++;
    if ({gamma_count, gamma_start, busy, output_spikes} !== {4'd0, 1'b1, 1'b1, 16'h0}) begin
      fails++;
      $display("FAIL bnd_restart: got cnt=%0d gs=%b busy=%b spk=%h want 0/1/1/0000",
               gamma_count, gamma_start, busy, output_spikes);
    end
    for (int c = 1; c < 16; c++) begin
      tick();
      tests++;
      if ({gamma_count, output_spikes} !== {4'(c), exp_spk(b, c)}) begin
        fails++;
        $display("FAIL bnd_b_c%0d: got cnt=%0d spk=%h want cnt=%0d spk=%h",
                 c, gamma_count, output_spikes, c, exp_spk(b, c));
      end
    end
    tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL bnd_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] v1, v2, v3;
    v1 = fill(4'd0);
    v2 = fill(4'd7);
    for (int i = 0; i < 16; i++) v3[i*4 +: 4] = 4'(i);
    in_values = v1; in_valid = 1'b1;
    tick();
    in_values = v2;
    for (int c = 1; c < 16; c++) begin
      tick();
      if (c == 1) in_values = v3;
      tests++;
      if ({gamma_count, output_spikes, in_ready} !== {4'(c), exp_spk(v1, c), 1'b0}) begin
        fails++;
        $display("FAIL bp_g1_c%0d: got cnt=%0d spk=%h rdy=%b want cnt=%0d spk=%h rdy=0",
                 c, gamma_count, output_spikes, in_ready, c, exp_spk(v1, c));
      end
    end
    tick();
    tests++;
    if ({gamma_count, gamma_start, in_ready} !== {4'd0, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL bp_g2_start: got cnt=%0d gs=%b rdy=%b want 0/1/1", gamma_count, gamma_start, in_ready);
    end
    for (int c = 1; c < 16; c++) begin
      tick();
      if (c == 1) begin
        in_valid = 1'b0; in_values = 64'h0;
        tests++;
        if (in_ready !== 1'b0) begin
          fails++;
          $display("FAIL bp_v3_staged: got rdy=%b want 0", in_ready);
        end
      end
      tests++;
      if ({gamma_count, output_spikes} !== {4'(c), exp_spk(v2, c)}) begin
        fails++;
        $display("FAIL bp_g2_c%0d: got cnt=%0d spk=%h want cnt=%0d spk=%h",
                 c, gamma_count, output_spikes, c, exp_spk(v2, c));
      end
    end
    tick();
    tests++;
    if ({gamma_count, gamma_start, busy} !== {4'd0, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL bp_g3_start: got cnt=%0d gs=%b busy=%b want 0/1/1", gamma_count, gamma_start, busy);
    end
    for (int c = 1; c < 16; c++) begin
      tick();
      tests++;
      if ({gamma_count, output_spikes} !== {4'(c), exp_spk(v3, c)}) begin
        fails++;
        $display("FAIL bp_g3_c%0d: got cnt=%0d spk=%h want cnt=%0d spk=%h",
                 c, gamma_count, output_spikes, c, exp_spk(v3, c));
      end
    end
    tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL bp_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    logic bad;
    in_values = fill(4'd2); in_valid = 1'b1;
    tick();
    in_values = fill(4'd5);
    tick();
    in_valid = 1'b0; in_values = 64'h0;
    tests++;
    if ({gamma_count, in_ready} !== {4'd1, 1'b0}) begin
      fails++;
      $display("FAIL rmid_staged: got cnt=%0d rdy=%b want 1/0", gamma_count, in_ready);
    end
    repeat (6) tick();
    tests++;
    if ({gamma_count, output_spikes} !== {4'd7, 16'hFFFF}) begin
      fails++;
      $display("FAIL rmid_pre: got cnt=%0d spk=%h want 7/ffff", gamma_count, output_spikes);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({output_spikes, gamma_start, gamma_count, busy, in_ready} !== {16'h0, 1'b0, 4'h0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL rmid_async: got spk=%h gs=%b cnt=%0d busy=%b rdy=%b want 0000/0/0/0/1",
               output_spikes, gamma_start, gamma_count, busy, in_ready);
    end
    #2 rst = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (output_spikes !== 16'h0 || busy !== 1'b0 || gamma_start !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
    end
    tests++;
    if (bad !== 1'b0) begin
      fails++;
      $display("FAIL rmid_discard: got activity after reset (flag=%b) want none", bad);
    end
  endtask

  task automatic test_ties();
    logic [63:0] v;
    int winner;
    v = fill(4'd3);
    in_values = v; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c < 16; c++) begin
      tick();
      tests++;
      if ({gamma_count, output_spikes} !== {4'(c), exp_spk(v, c)}) begin
        fails++;
        $display("FAIL ties_c%0d: got cnt=%0d spk=%h want cnt=%0d spk=%h",
                 c, gamma_count, output_spikes, c, exp_spk(v, c));
      end
      if (c == 4) begin
        winner = -1;
        for (int i = 15; i >= 0; i--) if (output_spikes[i]) winner = i;
        tests++;
        if (output_spikes !== 16'hFFFF || winner != 0) begin
          fails++;
          $display("FAIL ties_rise: got spk=%h winner=%0d want ffff winner=0", output_spikes, winner);
        end
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_boundary_accept();
    test_backpressure();
    test_reset_mid();
    test_ties();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
